// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_ctrl_pkg
// Purpose : Shared definitions for the register-file command controller.
//           This package holds the default geometry parameters and the
//           controller state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

  localparam int DEF_WIDTH  = 16;  // register-file word width
  localparam int DEF_DEPTH  = 8;   // implemented registers
  localparam int DEF_CMD_AW = 4;   // command address width (one spare bit)
  localparam int DEF_RF_AW  = 3;   // register-file address width
  localparam int TXN_CNT_W  = 16;  // completed-response counter width

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage : regfile_ctrl_pkg
`default_nettype wire

// File: rtl/regfile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : regfile_cmd_ctrl
// Purpose : Converts a valid/ready command stream (read/write + address)
//           into register-file strobes, and returns one valid/ready response
//           per command. Out-of-range addresses are answered with rsp_err and
//           never reach the register file.
// Ports   : clk/rst       - clock, asynchronous active-low reset
//           cmd_*         - command channel (valid/ready, write, addr, wdata)
//           rsp_*         - response channel (valid/ready, rdata, err)
//           rf_*          - register-file strobe/address/data interface
//           txn_cnt       - completed-response count (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module regfile_cmd_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CMD_AW = DEF_CMD_AW,
  parameter int RF_AW  = DEF_RF_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  // command channel
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [CMD_AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0]     cmd_wdata,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 rsp_err,
  // register-file side
  output logic                 rf_wrEN,
  output logic                 rf_rdEN,
  output logic [RF_AW-1:0]     rf_address,
  output logic [WIDTH-1:0]     rf_wrData,
  input  logic [WIDTH-1:0]     rf_rdData,
  // statistics
  output logic [TXN_CNT_W-1:0] txn_cnt
);

  state_t state_q, state_d;

  logic                 accept_w;
  logic                 in_range_w;

  logic [RF_AW-1:0]     addr_q;
  logic [WIDTH-1:0]     wdata_q;
  logic [WIDTH-1:0]     rdata_q;
  logic                 err_q;
  logic [TXN_CNT_W-1:0] txn_cnt_q;

  assign accept_w   = cmd_valid && (state_q == ST_IDLE);
  // Compared at 32 bits so the check stays correct even when DEPTH equals
  // 2**CMD_AW and would not fit in the command address width.
  assign in_range_w = (32'(cmd_addr) < 32'(DEPTH));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          if (!in_range_w)    state_d = ST_RESP;
          else if (cmd_write) state_d = ST_WRITE;
          else                state_d = ST_RD_REQ;
        end
      end
      ST_WRITE:   state_d = ST_RESP;
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command capture, response data and transaction counter.
  // The command is only ever sampled on acceptance, so the inputs are free to
  // change once the controller has left IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      txn_cnt_q <= '0;
    end else begin
      if (accept_w) begin
        // rf_address keeps its previous value for rejected commands.
        if (in_range_w) begin
          addr_q <= cmd_addr[RF_AW-1:0];
        end
        wdata_q <= cmd_wdata;
        rdata_q <= '0;
        err_q   <= !in_range_w;
      end
      // Sampling on the exit of RD_WAIT gives a registered register file its
      // one cycle of latency while still working with a combinational one.
      if (state_q == ST_RD_WAIT) begin
        rdata_q <= rf_rdData;
      end
      if ((state_q == ST_RESP) && rsp_ready) begin
        txn_cnt_q <= txn_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (purely from state so strobes drop as soon as reset hits)
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    rf_wrEN    = 1'b0;
    rf_rdEN    = 1'b0;
    rf_wrData  = '0;
    rf_address = addr_q;
    txn_cnt    = txn_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_WRITE: begin
        rf_wrEN   = 1'b1;
        rf_wrData = wdata_q;
      end
      ST_RD_REQ, ST_RD_WAIT: begin
        rf_rdEN = 1'b1;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule : regfile_cmd_ctrl
`default_nettype wire
